multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Parametrised, sequential successor to the single-cycle control decoder, for the multi-cycle RISC-V core. A state machine sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives datapath enables and a 4-bit ALU op. It uses a req/ready handshake with the unified memory, guarded by a timeout watchdog. It also keeps a retired-instruction counter and sticky trap flags for illegal opcodes and bus timeouts.

Parameters:
ALU_CTRL_W, 4, width of alu_control; must be >= 3.
TIMEOUT, 16, maximum cycles mem_req may wait for mem_ready before a bus error; >= 1.
CNT_W, 32, width of instret counter.

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
opcode  in  7  instr[6:0] from instruction register
funct3  in  3  instr[14:12]
funct7  in  7  instr[31:25]
alu_zero  in  1  ALU zero flag; valid in EXEC
mem_ready  in  1  memory accepted/completed the current request
mem_req  out  1  memory request; held until mem_ready
mem_we  out  1  write strobe; qualified by mem_req
ir_write  out  1  load instruction register with memory data
pc_write  out  1  PC <= PC+4 (end of FETCH) or branch target (taken BEQ)
pc_src  out  1  0 = PC+4, 1 = branch target
reg_write  out  1  register file write enable
alu_src  out  1  0 = rs2, 1 = immediate
mem_to_reg  out  1  writeback select: 1 = load data
alu_control  out  ALU_CTRL_W  ALU op: 0 ADD, 1 SUB, 2 XOR, 3 MOV, 4 AND, 5 OR
illegal  out  1  sticky: unsupported opcode/funct decoded
bus_err  out  1  sticky: memory timeout
instret  out  CNT_W  count of retired instructions

Behaviour:
- Reset: state = FETCH; every output is 0, including instret, illegal and bus_err. rst has priority over all other events. Any outstanding mem_req drops on the cycle after rst is sampled.
- Outputs are registered Moore outputs of the state, except pc_write/ir_write, which pulse for one cycle on the handshake-completing edge.
- FETCH: mem_req=1, mem_we=0. On the cycle where mem_ready=1: ir_write=1 and pc_write=1 (pc_src=0). Next state is DECODE.
- DECODE: opcode/funct are sampled into an internal class register and ALU op. Illegal encodings set illegal=1 and go to TRAP.
- Supported encodings:
  - R-type 0110011: funct3 000 with funct7 0000000 gives ADD, with 0100000 gives SUB; funct3 100/funct7 0 gives XOR; 111 gives AND; 110 gives OR. Any other funct3/funct7 combination is illegal.
  - 0010011 ADDI: MOV.
  - 0000011 LW: funct3 010 only, ADD.
  - 0100011 SW: funct3 010 only, ADD.
  - 1100011 BEQ: funct3 000 only, SUB.
- EXEC: alu_control/alu_src are driven.
  - R-type and ADDI go to WB.
  - LW and SW go to MEM.
  - BEQ: if alu_zero, pc_write=1 and pc_src=1. Then FETCH; BEQ retires here.
- MEM: mem_req=1, mem_we=1 for SW only.
  - On mem_ready, SW retires and goes to FETCH; LW goes to WB.
- WB: reg_write=1 for one cycle; mem_to_reg=1 for LW only. The instruction retires and the next state is FETCH.
- Retire: instret increments by 1 on the retiring edge and wraps at 2^CNT_W−1 to 0.
- Timeout: a wait counter clears on entry to FETCH/MEM and counts each cycle mem_req=1 && !mem_ready.
  - When it reaches TIMEOUT, bus_err=1, mem_req drops, and the next state is TRAP.
  - mem_ready arriving on the same edge the counter hits TIMEOUT counts as success; no error is raised.
- TRAP: all enables are 0 and the FSM stays in TRAP until rst. Flags persist.
- Zero-wait memory cycle counts: R/ADDI 4, LW 5, SW 4, BEQ 3.
- A mem_ready seen while mem_req=0 is ignored.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH);
  - ALU op codes (ALU_ADD..ALU_OR);
  - state enum (S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP);
  - instruction class enum.
- Sub-module instr_decode is pure combinational: opcode/funct3/funct7 in; class, alu op and illegal out. The FSM, timeout counter and instret stay in multicycle_control.

Test Plan:
- rst held 2 cycles mid-MEM of an SW → next cycle: mem_req=0, state FETCH, instret=0, flags 0.
- ADD (0110011/000/0000000), then SUB (funct7 0100000), then XOR, with mem_ready tied 1 → alu_control 0, 1, 2 in EXEC. Each instruction takes 4 cycles; reg_write is one pulse per instruction; instret=3.
- LW with mem_ready delayed 3 cycles in MEM → mem_req held 4 cycles; WB has mem_to_reg=1 and reg_write=1; total 8 cycles.
- BEQ with alu_zero=1, then BEQ with alu_zero=0 → first gives pc_write=1/pc_src=1 in EXEC, second gives no pc_write in EXEC. Both take 3 cycles.
- Opcode 1111111, and R-type funct7 0100000/funct3 100 → illegal=1 after DECODE; FSM stuck in TRAP with no enables until rst.
- TIMEOUT=16, mem_ready never asserted in FETCH → bus_err=1 after 16 wait cycles. A second run with mem_ready on wait cycle 16 → no error.

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcodes, ALU op codes, FSM states and instruction classes for multicycle_control
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam int         ALU_OP_W = 3;
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_XOR  = 3'd2;
  localparam logic [2:0] ALU_MOV  = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;
  localparam logic [2:0] ALU_OR   = 3'd5;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    C_NONE,
    C_ALU,
    C_IMM,
    C_LOAD,
    C_STORE,
    C_BRANCH
  } iclass_t;

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational opcode/funct decode into instruction class, ALU op and illegal flag
module instr_decode
  import ctrl_pkg::*;
(
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  output iclass_t             iclass,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal
);

  always_comb begin
    iclass  = C_NONE;
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        iclass = C_ALU;
        case ({funct7, funct3})
          {F7_BASE, 3'b000}: alu_op = ALU_ADD;
          {F7_ALT,  3'b000}: alu_op = ALU_SUB;
          {F7_BASE, 3'b100}: alu_op = ALU_XOR;
          {F7_BASE, 3'b111}: alu_op = ALU_AND;
          {F7_BASE, 3'b110}: alu_op = ALU_OR;
          default: begin
            iclass  = C_NONE;
            illegal = 1'b1;
          end
        endcase
      end
      OP_IMM: begin
        iclass = C_IMM;
        alu_op = ALU_MOV;
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) iclass = C_LOAD;
        else                  illegal = 1'b1;
      end
      OP_STORE: begin
        if (funct3 == 3'b010) iclass = C_STORE;
        else                  illegal = 1'b1;
      end
      OP_BRANCH: begin
        if (funct3 == 3'b000) begin
          iclass = C_BRANCH;
          alu_op = ALU_SUB;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle RISC-V control FSM with memory handshake watchdog, instret and trap flags
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 4,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  alu_zero,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  pc_src,
  output logic                  reg_write,
  output logic                  alu_src,
  output logic                  mem_to_reg,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  illegal,
  output logic                  bus_err,
  output logic [CNT_W-1:0]      instret
);

  localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t                state, next_state;
  iclass_t               cls_q, cls_n, dec_cls;
  logic [ALU_OP_W-1:0]   alu_q, alu_n, dec_alu;
  logic                  dec_illegal;
  logic [WAIT_W-1:0]     wait_cnt;
  logic                  req_done, req_wait, timeout_hit, retire;
  logic                  mem_req_n, mem_we_n, reg_write_n, mem_to_reg_n, alu_src_n, pc_src_n;
  logic [ALU_CTRL_W-1:0] alu_control_n;

  instr_decode u_decode (
    .opcode  (opcode),
    .funct3  (funct3),
    .funct7  (funct7),
    .iclass  (dec_cls),
    .alu_op  (dec_alu),
    .illegal (dec_illegal)
  );

  // mem_req is the registered request, so a mem_ready while it is low never completes anything
  assign req_done    = mem_req && mem_ready;
  assign req_wait    = mem_req && !mem_ready;
  assign timeout_hit = req_wait && (wait_cnt == WAIT_LAST);

  assign ir_write = !rst && (state == S_FETCH) && req_done;
  assign pc_write = ir_write || (!rst && (state == S_EXEC) && (cls_q == C_BRANCH) && alu_zero);
  assign retire   = ((state == S_EXEC) && (cls_q == C_BRANCH))
                 || ((state == S_MEM) && (cls_q == C_STORE) && req_done)
                 || (state == S_WB);

  assign cls_n = (state == S_DECODE) ? dec_cls : cls_q;
  assign alu_n = (state == S_DECODE) ? dec_alu : alu_q;

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH: begin
        if (req_done)         next_state = S_DECODE;
        else if (timeout_hit) next_state = S_TRAP;
      end
      S_DECODE: next_state = dec_illegal ? S_TRAP : S_EXEC;
      S_EXEC: begin
        case (cls_q)
          C_LOAD, C_STORE: next_state = S_MEM;
          C_BRANCH:        next_state = S_FETCH;
          default:         next_state = S_WB;
        endcase
      end
      S_MEM: begin
        if (req_done)         next_state = (cls_q == C_LOAD) ? S_WB : S_FETCH;
        else if (timeout_hit) next_state = S_TRAP;
      end
      S_WB:    next_state = S_FETCH;
      default: next_state = S_TRAP;
    endcase
  end

  // Moore outputs are computed for the state being entered and registered with it
  always_comb begin
    mem_req_n     = (next_state == S_FETCH) || (next_state == S_MEM);
    mem_we_n      = (next_state == S_MEM) && (cls_n == C_STORE);
    reg_write_n   = (next_state == S_WB);
    mem_to_reg_n  = (next_state == S_WB) && (cls_n == C_LOAD);
    alu_src_n     = (next_state == S_EXEC) && (cls_n inside {C_IMM, C_LOAD, C_STORE});
    pc_src_n      = (next_state == S_EXEC) && (cls_n == C_BRANCH);
    alu_control_n = (next_state == S_EXEC) ? ALU_CTRL_W'(alu_n) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      cls_q       <= C_NONE;
      alu_q       <= ALU_ADD;
      wait_cnt    <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      reg_write   <= 1'b0;
      mem_to_reg  <= 1'b0;
      alu_src     <= 1'b0;
      pc_src      <= 1'b0;
      alu_control <= '0;
      illegal     <= 1'b0;
      bus_err     <= 1'b0;
      instret     <= '0;
    end else begin
      state       <= next_state;
      cls_q       <= cls_n;
      alu_q       <= alu_n;
      mem_req     <= mem_req_n;
      mem_we      <= mem_we_n;
      reg_write   <= reg_write_n;
      mem_to_reg  <= mem_to_reg_n;
      alu_src     <= alu_src_n;
      pc_src      <= pc_src_n;
      alu_control <= alu_control_n;
      if (next_state != state) wait_cnt <= '0;
      else if (req_wait)       wait_cnt <= wait_cnt + WAIT_W'(1);
      if ((state == S_DECODE) && dec_illegal) illegal <= 1'b1;
      if (timeout_hit)                        bus_err <= 1'b1;
      if (retire)                             instret <= instret + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized scoreboard bench for multicycle_control
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [6:0]  funct7 = 7'd0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, alu_src, mem_to_reg;
  logic [3:0]  alu_control;
  logic        illegal, bus_err;
  logic [31:0] instret;

  multicycle_control #(.ALU_CTRL_W(4), .TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
    .alu_src(alu_src), .mem_to_reg(mem_to_reg), .alu_control(alu_control),
    .illegal(illegal), .bus_err(bus_err), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cycles; int alu; int src; int rw; int m2r; int we; int req; int taken;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  // kinds: 0 ADD 1 SUB 2 XOR 3 AND 4 OR 5 ADDI 6 LW 7 SW 8 BEQ
  function automatic exp_t model(input int kind, input int fd, input int md, input bit z, input bit first);
    exp_t e;
    bit   is_mem;
    int   base;
    is_mem = (kind == 6) || (kind == 7);
    case (kind)
      0: e.alu = 0;  1: e.alu = 1;  2: e.alu = 2;  3: e.alu = 4;  4: e.alu = 5;
      5: e.alu = 3;  6: e.alu = 0;  7: e.alu = 0;  default: e.alu = 1;
    endcase
    base     = (kind == 6) ? 5 : (kind == 8) ? 3 : 4;
    e.src    = (kind >= 5 && kind <= 7) ? 1 : 0;
    e.rw     = (kind <= 6) ? 1 : 0;
    e.m2r    = (kind == 6) ? 1 : 0;
    e.we     = (kind == 7) ? md + 1 : 0;
    e.req    = fd + 1 + (is_mem ? md + 1 : 0);
    e.taken  = (kind == 8 && z) ? 1 : 0;
    e.cycles = base + fd + (is_mem ? md : 0) + (first ? 1 : 0);
    return e;
  endfunction

  task automatic encode(input int kind, output logic [6:0] op, output logic [2:0] f3, output logic [6:0] f7);
    f7 = 7'($urandom);
    f3 = 3'b000;
    case (kind)
      0: begin op = 7'b0110011; f7 = 7'h00; end
      1: begin op = 7'b0110011; f7 = 7'h20; end
      2: begin op = 7'b0110011; f7 = 7'h00; f3 = 3'b100; end
      3: begin op = 7'b0110011; f7 = 7'h00; f3 = 3'b111; end
      4: begin op = 7'b0110011; f7 = 7'h00; f3 = 3'b110; end
      5: op = 7'b0010011;
      6: begin op = 7'b0000011; f3 = 3'b010; end
      7: begin op = 7'b0100011; f3 = 3'b010; end
      default: op = 7'b1100011;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!mem_req && n < 60) begin
      tick();
      n++;
    end
    if (!mem_req) check(tag, int'(mem_req), 1);
  endtask

  task automatic handshake(input int delay);
    wait_req("mem_req_rise_timeout");
    repeat (delay) tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
  endtask

  task automatic run_instr(input int kind, input int fd, input int md, input bit z, input bit first);
    logic [6:0] op, f7;
    logic [2:0] f3;
    exp_q.push_back(model(kind, fd, md, z, first));
    encode(kind, op, f3, f7);
    handshake(fd);
    opcode = op; funct3 = f3; funct7 = f7; alu_zero = z;
    if (kind == 6 || kind == 7) handshake(md);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst = 1'b1;
    mem_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic stuck_check(input string tag, input bit exp_ill, input bit exp_be);
    int en = 0;
    for (int i = 0; i < 8; i++) begin
      mem_ready = ($urandom_range(0, 1) == 1);
      alu_zero  = ($urandom_range(0, 1) == 1);
      #1;
      if (mem_req || mem_we || ir_write || pc_write || reg_write || mem_to_reg || alu_src || (alu_control != 0))
        en++;
      tick();
    end
    mem_ready = 1'b0;
    check({tag, "_enables"}, en, 0);
    check({tag, "_illegal"}, int'(illegal), int'(exp_ill));
    check({tag, "_bus_err"}, int'(bus_err), int'(exp_be));
  endtask

  // monitor: accumulates observations per instruction, compares on every instret step
  int          cyc = 0, rw_cnt = 0, m2r = 0, we_cnt = 0, req_cnt = 0, pcw_other = 0, since_ir = 99;
  int          ex_alu = 0, ex_src = 0, ex_pcw = 0, ex_pcsrc = 0;
  logic [31:0] last_instret = 32'd0;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (rst || !mon_en) begin
      cyc = 0; rw_cnt = 0; m2r = 0; we_cnt = 0; req_cnt = 0; pcw_other = 0; since_ir = 99;
      last_instret = instret;
    end else begin
      if (instret != last_instret) begin
        if (exp_q.size() == 0) begin
          check("unexpected_retire", int'(instret), int'(last_instret));
        end else begin
          mon_e = exp_q.pop_front();
          check("cycles", cyc, mon_e.cycles);
          check("exec_alu_control", ex_alu, mon_e.alu);
          check("exec_alu_src", ex_src, mon_e.src);
          check("reg_write_pulses", rw_cnt, mon_e.rw);
          check("mem_to_reg", m2r, mon_e.m2r);
          check("mem_we_cycles", we_cnt, mon_e.we);
          check("mem_req_cycles", req_cnt, mon_e.req);
          check("exec_pc_write", ex_pcw, mon_e.taken);
          if (mon_e.taken == 1) check("exec_pc_src", ex_pcsrc, 1);
          check("stray_pc_write", pcw_other, 0);
          check("instret_step", int'(instret - last_instret), 1);
        end
        cyc = 0; rw_cnt = 0; m2r = 0; we_cnt = 0; req_cnt = 0; pcw_other = 0;
        last_instret = instret;
      end
      cyc++;
      if (ir_write) since_ir = 0;
      else if (since_ir < 99) since_ir++;
      if (since_ir == 2) begin
        ex_alu = int'(alu_control); ex_src = int'(alu_src);
        ex_pcw = int'(pc_write);    ex_pcsrc = int'(pc_src);
      end
      if (reg_write) begin
        rw_cnt++;
        if (mem_to_reg) m2r = 1;
      end
      if (mem_req && mem_we) we_cnt++;
      if (mem_req) req_cnt++;
      if (pc_write && !ir_write && since_ir != 2) pcw_other++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int waits;
    logic [6:0] op, f7;
    logic [2:0] f3;

    tick();
    tick();
    check("rst_mem_req", int'(mem_req), 0);
    check("rst_mem_we", int'(mem_we), 0);
    check("rst_ir_write", int'(ir_write), 0);
    check("rst_pc_write", int'(pc_write), 0);
    check("rst_reg_write", int'(reg_write), 0);
    check("rst_alu_control", int'(alu_control), 0);
    check("rst_illegal", int'(illegal), 0);
    check("rst_bus_err", int'(bus_err), 0);
    check("rst_instret", int'(instret), 0);
    rst = 1'b0;
    mon_en = 1'b1;

    run_instr(0, 0, 0, 1'b0, 1'b1);
    run_instr(1, 0, 0, 1'b0, 1'b0);
    run_instr(2, 0, 0, 1'b0, 1'b0);
    run_instr(6, 0, 3, 1'b0, 1'b0);
    run_instr(8, 0, 0, 1'b1, 1'b0);
    run_instr(8, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++)
      run_instr(int'($urandom_range(0, 8)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                $urandom_range(0, 1) == 1, 1'b0);
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    check("instret_total", int'(instret), 46);
    mon_en = 1'b0;

    // reset in the middle of an SW memory wait
    encode(7, op, f3, f7);
    handshake(0);
    opcode = op; funct3 = f3; funct7 = f7;
    wait_req("sw_mem_req");
    tick();
    tick();
    check("sw_mem_we", int'(mem_we), 1);
    rst = 1'b1;
    tick();
    check("midmem_rst_mem_req", int'(mem_req), 0);
    check("midmem_rst_instret", int'(instret), 0);
    check("midmem_rst_flags", int'({illegal, bus_err}), 0);
    tick();
    rst = 1'b0;
    check("post_rst_req_low", int'(mem_req), 0);
    tick();
    check("post_rst_fetch_req", int'(mem_req), 1);

    // unsupported opcode; mem_ready before the first request must be ignored
    do_reset();
    mem_ready = 1'b1;
    #1;
    check("ready_without_req", int'(ir_write), 0);
    tick();
    check("fetch_ir_write", int'(ir_write), 1);
    tick();
    mem_ready = 1'b0;
    opcode = 7'b1111111; funct3 = 3'b000; funct7 = 7'h00;
    tick();
    check("illegal_opcode_flag", int'(illegal), 1);
    stuck_check("trap_opcode", 1'b1, 1'b0);

    // R-type with SUB funct7 on the XOR funct3
    do_reset();
    check("illegal_cleared", int'(illegal), 0);
    handshake(0);
    opcode = 7'b0110011; funct3 = 3'b100; funct7 = 7'b0100000;
    tick();
    check("illegal_funct_flag", int'(illegal), 1);
    stuck_check("trap_funct", 1'b1, 1'b0);

    // fetch never answered
    do_reset();
    n = 0;
    waits = 0;
    while (!bus_err && n < 100) begin
      if (mem_req) waits++;
      tick();
      n++;
    end
    check("timeout_wait_cycles", waits, 16);
    check("timeout_bus_err", int'(bus_err), 1);
    check("timeout_req_drop", int'(mem_req), 0);
    stuck_check("trap_timeout", 1'b0, 1'b1);

    // ready on the last permitted request cycle is a success
    do_reset();
    check("bus_err_cleared", int'(bus_err), 0);
    wait_req("edge_req");
    repeat (15) tick();
    mem_ready = 1'b1;
    #1;
    check("edge_ready_ir_write", int'(ir_write), 1);
    tick();
    mem_ready = 1'b0;
    encode(0, op, f3, f7);
    opcode = op; funct3 = f3; funct7 = f7;
    check("edge_ready_no_err", int'(bus_err), 0);
    repeat (4) tick();
    check("edge_ready_still_no_err", int'(bus_err), 0);
    check("edge_ready_retired", int'(instret), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
